// File: rtl/maquina_senha_param.sv
// -----------------------------------------------------------------------------
// maquina_senha_param
//
// Parametrised digit-entry lock. Digits arrive one per strobe, most-significant
// code digit first, and are checked against CODE as they arrive. A correct
// attempt lights LED for OPEN_CYCLES cycles. A wrong attempt pulses erro for
// one cycle. MAX_TRIES consecutive wrong attempts start a lockout that lasts
// LOCK_CYCLES cycles and shows a dash on the display.
//
// Parameters:
//   N_DIGITS    digits per code (2..8)
//   DIGIT_W     bits per digit (4..8); the display decodes numero[4:1]
//   CODE        packed code, first digit entered in the most-significant slot
//   MAX_TRIES   consecutive wrong attempts before lockout (1..15)
//   OPEN_CYCLES cycles LED stays high after a correct attempt (>=1)
//   LOCK_CYCLES lockout length in cycles (>=1)
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous, active-high reset
//   insere     digit strobe, one digit accepted per cycle while high
//   numero     digit value
//   LED        unlocked indicator
//   A..G       seven-segment outputs, active-high, registered
//   erro       one-cycle pulse on a wrong completed attempt
//   bloqueado  high during lockout
//   digitos    digits accepted so far in the current attempt
// -----------------------------------------------------------------------------
module maquina_senha_param #(
    parameter int                            N_DIGITS    = 4,
    parameter int                            DIGIT_W     = 4,
    parameter logic [N_DIGITS*DIGIT_W-1:0]   CODE        = 'h5909,
    parameter int                            MAX_TRIES   = 3,
    parameter int                            OPEN_CYCLES = 8,
    parameter int                            LOCK_CYCLES = 16
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              insere,
    input  logic [DIGIT_W:1]                  numero,
    output logic                              LED,
    output logic                              A,
    output logic                              B,
    output logic                              C,
    output logic                              D,
    output logic                              E,
    output logic                              F,
    output logic                              G,
    output logic                              erro,
    output logic                              bloqueado,
    output logic [$clog2(N_DIGITS+1)-1:0]     digitos
);

    localparam int CNT_W   = $clog2(N_DIGITS + 1);
    localparam int TMR_MAX = (OPEN_CYCLES > LOCK_CYCLES) ? OPEN_CYCLES : LOCK_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(N_DIGITS - 1);
    localparam logic [TMR_W-1:0] OPEN_LOAD = TMR_W'(OPEN_CYCLES - 1);
    localparam logic [TMR_W-1:0] LOCK_LOAD = TMR_W'(LOCK_CYCLES - 1);
    localparam logic [3:0]       TRIES_LIM = 4'(MAX_TRIES);

    localparam logic [6:0] SEG_BLANK = 7'b0000000;
    localparam logic [6:0] SEG_DASH  = 7'b0000001;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ENTRY  = 2'd1,
        OPEN   = 2'd2,
        LOCKED = 2'd3
    } state_t;

    state_t             state;
    logic               mismatch;
    logic [3:0]         fail_cnt;
    logic [3:0]         fail_next;
    logic [TMR_W-1:0]   timer;
    logic [6:0]         seg;
    logic [DIGIT_W-1:0] code_digit;
    logic               digit_bad;
    logic               attempt_bad;

    // Segment order is {A,B,C,D,E,F,G}; standard hex glyphs with lowercase b and d.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0:    s = 7'b1111110;
            4'h1:    s = 7'b0110000;
            4'h2:    s = 7'b1101101;
            4'h3:    s = 7'b1111001;
            4'h4:    s = 7'b0110011;
            4'h5:    s = 7'b1011011;
            4'h6:    s = 7'b1011111;
            4'h7:    s = 7'b1110000;
            4'h8:    s = 7'b1111111;
            4'h9:    s = 7'b1111011;
            4'hA:    s = 7'b1110111;
            4'hB:    s = 7'b0011111;
            4'hC:    s = 7'b1001110;
            4'hD:    s = 7'b0111101;
            4'hE:    s = 7'b1001111;
            default: s = 7'b1000111;
        endcase
        return s;
    endfunction

    // The expected digit is picked straight out of CODE by the current position,
    // so only a sticky mismatch bit is needed instead of a buffer of entered digits.
    always_comb begin
        code_digit = '0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (digitos == CNT_W'(i)) begin
                code_digit = CODE[(N_DIGITS-1-i)*DIGIT_W +: DIGIT_W];
            end
        end
    end

    assign digit_bad   = (numero != code_digit);
    assign attempt_bad = mismatch | digit_bad;
    assign fail_next   = fail_cnt + 4'd1;

    assign {A, B, C, D, E, F, G} = seg;

    // Whole controller: digit acceptance, attempt evaluation, open and lockout
    // timers. Timers are loaded with N-1 and the exit happens on the edge that
    // sees zero, giving exactly N cycles of LED or bloqueado.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            LED       <= 1'b0;
            erro      <= 1'b0;
            bloqueado <= 1'b0;
            digitos   <= '0;
            seg       <= SEG_BLANK;
            fail_cnt  <= 4'd0;
            timer     <= '0;
            mismatch  <= 1'b0;
        end else begin
            erro <= 1'b0;
            case (state)
                IDLE, ENTRY: begin
                    if (insere) begin
                        seg <= hex_to_seg(numero[4:1]);
                        if (digitos == LAST_IDX) begin
                            digitos  <= '0;
                            mismatch <= 1'b0;
                            if (!attempt_bad) begin
                                state    <= OPEN;
                                LED      <= 1'b1;
                                fail_cnt <= 4'd0;
                                timer    <= OPEN_LOAD;
                            end else begin
                                erro <= 1'b1;
                                if (fail_next == TRIES_LIM) begin
                                    state     <= LOCKED;
                                    bloqueado <= 1'b1;
                                    seg       <= SEG_DASH;
                                    fail_cnt  <= 4'd0;
                                    timer     <= LOCK_LOAD;
                                end else begin
                                    state    <= IDLE;
                                    fail_cnt <= fail_next;
                                end
                            end
                        end else begin
                            digitos  <= digitos + 1'b1;
                            mismatch <= attempt_bad;
                            state    <= ENTRY;
                        end
                    end
                end
                OPEN: begin
                    if (timer == '0) begin
                        state <= IDLE;
                        LED   <= 1'b0;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                LOCKED: begin
                    if (timer == '0) begin
                        state     <= IDLE;
                        bloqueado <= 1'b0;
                        seg       <= SEG_BLANK;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/maquina_senha_param.md
Name: maquina_senha_param

Overview:
- Parametrised successor to the single-code digit-entry machine: accepts a stream of DIGIT_W-bit digits, compares them against an N_DIGITS-digit code, and drives an unlock LED.
- Adds a seven-segment echo of the last accepted digit, a per-attempt error pulse, a failed-attempt counter and a timed lockout.
- Sits between the keypad/switch front end and the board LED/7-segment display.

Parameters:
- N_DIGITS, 4, number of digits in the code (2..8).
- DIGIT_W, 4, bits per digit (4..8); display shows numero[4:1] only.
- CODE, 32'h5909, packed code, N_DIGITS*DIGIT_W bits used; first digit entered = most-significant digit.
- MAX_TRIES, 3, consecutive wrong attempts that trigger lockout (1..15).
- OPEN_CYCLES, 8, cycles LED stays high after a correct code (>=1).
- LOCK_CYCLES, 16, lockout duration in cycles (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- insere  in  1  digit strobe; one digit is accepted per cycle while high.
- numero  in  DIGIT_W (numero[DIGIT_W:1])  digit value.
- LED  out  1  unlocked indicator.
- A,B,C,D,E,F,G  out  1 each  seven-segment outputs, active-high, registered.
- erro  out  1  one-cycle pulse on a wrong completed attempt.
- bloqueado  out  1  high during lockout.
- digitos  out  clog2(N_DIGITS+1)  digits accepted in the current attempt.

Behaviour:
- All outputs are registered. When reset is high at a clock edge: state=IDLE, LED=0, erro=0, bloqueado=0, digitos=0, A..G=0 (blank), fail counter=0, timers=0. Reset overrides every other input in the same cycle, including mid-attempt, OPEN and LOCKED.
- States: IDLE (no digits yet), ENTRY (1..N_DIGITS-1 digits), OPEN, LOCKED.
- Digit acceptance (IDLE/ENTRY, insere=1 at an edge):
  - Accept numero and increment digitos.
  - Compare the digit against the code digit at index digitos (MS-first); a mismatch sets a sticky mismatch flag for the attempt. The full code is not stored in a buffer.
  - Latch the seven-segment pattern for numero[4:1] (standard hex 0-F; for 1: B,C=1).
- Attempt completion: the N_DIGITS-th accepted digit completes the attempt at that same edge.
  - Correct (no mismatch): next state OPEN, LED=1, fail counter cleared, digitos=0.
  - Wrong: erro=1 for exactly one cycle, fail counter +1, digitos=0, mismatch flag cleared.
    - If the new count == MAX_TRIES: next state LOCKED, bloqueado=1, A..G = dash (G=1 only), fail counter cleared.
    - Otherwise: next state IDLE.
- OPEN: insere is ignored. LED stays high for exactly OPEN_CYCLES cycles, then the machine returns to IDLE with LED=0. Display holds the last digit.
- LOCKED: insere is ignored and the display shows the dash. After exactly LOCK_CYCLES cycles: IDLE, bloqueado=0, A..G blank.
- insere=0 holds all state. There is no entry timeout.
- Back-to-back digits on consecutive cycles are legal. A digit arriving on the cycle the state enters IDLE from OPEN or LOCKED is accepted normally.
- Only erro is a pulse; all other outputs are levels.

Test Plan:
- Reset, then insere one cycle each with 5,9,0,9 -> digitos goes 1,2,3 then 0; LED=1 the cycle after the 4th digit and stays high for exactly 8 cycles; A..G shows "9" (A,B,C,D,F,G=1, E=0).
- Enter 5,9,0,8 -> erro=1 for exactly one cycle after the 4th digit, LED stays 0, fail count=1, display shows "8".
- Three wrong attempts in a row -> bloqueado=1 and only G=1 for 16 cycles; insere pulses during lockout change nothing; then IDLE with A..G blank.
- Two wrong attempts, then the correct code -> LED=1 and fail count cleared; one further wrong attempt does not lock.
- Assert reset after entering 5,9 -> next cycle digitos=0 and A..G=0; a following 5,9,0,9 opens the lock. Assert reset during OPEN -> LED=0 next cycle.
- Hold insere=1 continuously with numero=5,9,0,9 changing every cycle -> opens; digits presented during OPEN are ignored; the first digit in the cycle after OPEN ends is accepted (digitos=1).
